div_sequencer: RTL

Multi-cycle RV32M divide/remainder unit that sequences a shared 32-bit subtract/shift datapath over 32 iterations. It executes DIV, DIVU, REM and REMU, which the single-cycle ALU does not implement. It sits beside the ALU in the instruction decoder: the decoder raises `Start`, stalls while `Busy` is high, and takes `Output` on the `Done` pulse. Divide-by-zero and signed overflow complete on a one-cycle fast path.

---
 rtl/div_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Uses restoring division over 32 iterations of a shared subtract/shift datapath.
// Divide-by-zero and signed overflow finish on a one-cycle fast path.
module div_sequencer #(
    parameter int unsigned UUID = 0,
    parameter string       NAME = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [31:0] Instruction,
    input  logic [31:0] Register_1,
    input  logic [31:0] Register_2,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [31:0] Output
);

    // Identity parameters carry no function; they only tag the instance.
    if ((UUID == 0) && (NAME == "")) begin : g_untagged_instance
    end else begin : g_tagged_instance
    end

    typedef enum logic [1:0] {StIdle, StBusy, StFixup, StDone} state_e;

    state_e      r_state, r_state_d;
    logic [4:0]  r_count, r_count_d;
    logic [31:0] r_quot, r_quot_d;
    logic [31:0] r_rem, r_rem_d;
    logic [31:0] r_divisor, r_divisor_d;
    logic        r_want_rem, r_want_rem_d;
    logic        r_neg_q, r_neg_q_d;
    logic        r_neg_r, r_neg_r_d;
    logic [31:0] r_out, r_out_d;
    logic        r_error, r_error_d;

    // Instruction decode and operand conditioning for the accepting cycle.
    logic        w_valid;
    logic        w_signed;
    logic        w_want_rem;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div0;
    logic        w_ovf;

    assign w_valid    = (Instruction[6:0] == 7'b0110011) &&
                        (Instruction[31:25] == 7'b0000001) && Instruction[14];
    assign w_signed   = ~Instruction[12];
    assign w_want_rem = Instruction[13];
    assign w_a_neg    = w_signed & Register_1[31];
    assign w_b_neg    = w_signed & Register_2[31];
    // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
    assign w_a_mag    = w_a_neg ? (~Register_1 + 32'd1) : Register_1;
    assign w_b_mag    = w_b_neg ? (~Register_2 + 32'd1) : Register_2;
    assign w_div0     = (Register_2 == 32'd0);
    assign w_ovf      = w_signed && (Register_1 == 32'h8000_0000) &&
                        (Register_2 == 32'hFFFF_FFFF);

    // One restoring step: the remainder stays below the divisor, so 32 bits hold it
    // between steps; only the shifted trial needs the 33rd bit.
    logic [32:0] w_shift_rem;
    logic [32:0] w_trial;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_shift_rem = {r_rem, r_quot[31]};
    assign w_trial     = w_shift_rem - {1'b0, r_divisor};
    assign w_quot_fix  = r_neg_q ? (~r_quot + 32'd1) : r_quot;
    assign w_rem_fix   = r_neg_r ? (~r_rem + 32'd1) : r_rem;

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        r_state_d    = r_state;
        r_count_d    = r_count;
        r_quot_d     = r_quot;
        r_rem_d      = r_rem;
        r_divisor_d  = r_divisor;
        r_want_rem_d = r_want_rem;
        r_neg_q_d    = r_neg_q;
        r_neg_r_d    = r_neg_r;
        r_out_d      = r_out;
        r_error_d    = 1'b0;

        case (r_state)
            StIdle: begin
                if (Start) begin
                    if (w_valid) begin
                        r_want_rem_d = w_want_rem;
                        r_neg_q_d    = w_a_neg ^ w_b_neg;
                        r_neg_r_d    = w_a_neg;
                        r_divisor_d  = w_b_mag;
                        r_quot_d     = w_a_mag;
                        r_rem_d      = 32'd0;
                        r_count_d    = 5'd0;
                        if (w_div0) begin
                            r_out_d   = w_want_rem ? Register_1 : 32'hFFFF_FFFF;
                            r_state_d = StDone;
                        end else if (w_ovf) begin
                            r_out_d   = w_want_rem ? 32'd0 : 32'h8000_0000;
                            r_state_d = StDone;
                        end else begin
                            r_state_d = StBusy;
                        end
                    end else begin
                        r_error_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (!w_trial[32]) begin
                    r_rem_d  = w_trial[31:0];
                    r_quot_d = {r_quot[30:0], 1'b1};
                end else begin
                    r_rem_d  = w_shift_rem[31:0];
                    r_quot_d = {r_quot[30:0], 1'b0};
                end
                r_count_d = r_count + 5'd1;
                if (r_count == 5'd31) begin
                    r_state_d = StFixup;
                end
            end
            StFixup: begin
                r_out_d   = r_want_rem ? w_rem_fix : w_quot_fix;
                r_state_d = StDone;
            end
            StDone: begin
                r_state_d = StIdle;
            end
            default: begin
                r_state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_count    <= 5'd0;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
            r_divisor  <= 32'd0;
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_out      <= 32'd0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= r_state_d;
            r_count    <= r_count_d;
            r_quot     <= r_quot_d;
            r_rem      <= r_rem_d;
            r_divisor  <= r_divisor_d;
            r_want_rem <= r_want_rem_d;
            r_neg_q    <= r_neg_q_d;
            r_neg_r    <= r_neg_r_d;
            r_out      <= r_out_d;
            r_error    <= r_error_d;
        end
    end

    assign Busy   = (r_state != StIdle);
    assign Done   = (r_state == StDone);
    assign Error  = r_error;
    assign Output = r_out;

endmodule
